// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
//   Serial pattern detector. Accepts a 1-bit stream (first bit received lands
//   in the pattern MSB) qualified by din_valid. It pulses match for one cycle
//   when the last DATA_WIDTH accepted bits equal the loadable pattern register,
//   and keeps a saturating match count.
//
//   Optional feature (macro SEQ_DET_PERIOD_EN): measures the number of accepted
//   bits between successive matches (period) and flags period_lock when the
//   last two periods are equal. Without the macro both outputs are tied to 0.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   din          in   serial data bit
//   din_valid    in   din is accepted on this edge when 1
//   load_pat     in   load pat into the pattern register (wins over din_valid)
//   pat          in   new pattern, MSB = first bit received
//   match        out  one-cycle pulse, registered, after the completing bit
//   match_cnt    out  saturating match count
//   busy_fill    out  1 while fewer than DATA_WIDTH bits are in the history
//   period       out  accepted bits between the last two matches
//   period_lock  out  last two periods equal
// -----------------------------------------------------------------------------
module seq_detector #(
    parameter int unsigned           DATA_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] PAT_INIT   = 6'b110011,
    parameter bit                    OVERLAP    = 1'b1,
    parameter int unsigned           CNT_W      = 8,
    parameter int unsigned           PER_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic                  din_valid,
    input  logic                  load_pat,
    input  logic [DATA_WIDTH-1:0] pat,
    output logic                  match,
    output logic [CNT_W-1:0]      match_cnt,
    output logic                  busy_fill,
    output logic [PER_W-1:0]      period,
    output logic                  period_lock
);

    localparam int unsigned     FW        = $clog2(DATA_WIDTH + 1);
    localparam logic [FW-1:0]   FILL_FULL = FW'(DATA_WIDTH);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HUNT = 1'b1
    } state_t;

    state_t                  r_state, w_state_nxt;
    // Only the newest DATA_WIDTH-1 bits are stored: the incoming bit completes
    // the comparison window, so the oldest bit is never needed afterwards.
    logic [DATA_WIDTH-2:0]   r_hist, w_hist_nxt;
    logic [FW-1:0]           r_fill, w_fill_nxt;
    logic [DATA_WIDTH-1:0]   r_pat, w_pat_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic                    r_match, w_match_nxt;

    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_hist_sh;
    logic [FW-1:0]           w_fill_inc;
    logic                    w_hit;

    always_comb begin
        w_accept    = din_valid && !load_pat;
        w_hist_sh   = {r_hist, din};
        w_fill_inc  = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
        w_hit       = w_accept && (w_hist_sh == r_pat) && (w_fill_inc == FILL_FULL);

        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_pat_nxt   = r_pat;
        w_cnt_nxt   = r_cnt;
        w_match_nxt = 1'b0;

        if (load_pat) begin
            w_pat_nxt   = pat;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_FILL;
        end else if (w_accept) begin
            w_hist_nxt  = w_hist_sh[DATA_WIDTH-2:0];
            w_fill_nxt  = w_fill_inc;
            w_state_nxt = (w_fill_inc == FILL_FULL) ? S_HUNT : S_FILL;
            if (w_hit) begin
                w_match_nxt = 1'b1;
                if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                // Non-overlapping mode: require a full window of fresh bits.
                if (!OVERLAP) begin
                    w_fill_nxt  = '0;
                    w_state_nxt = S_FILL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= PAT_INIT;
            r_cnt   <= '0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_pat   <= w_pat_nxt;
            r_cnt   <= w_cnt_nxt;
            r_match <= w_match_nxt;
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign busy_fill = (r_state == S_FILL);

`ifdef SEQ_DET_PERIOD_EN
    logic [PER_W-1:0] r_per_cnt, w_per_cnt_nxt;
    logic [PER_W-1:0] r_period, w_period_nxt;
    logic [PER_W-1:0] w_per_new;
    logic             r_lock, w_lock_nxt;
    logic             r_one_match, w_one_match_nxt;

    always_comb begin
        // Accepts since the last match, counting the current bit (saturating).
        w_per_new       = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + 1'b1;

        w_per_cnt_nxt   = r_per_cnt;
        w_period_nxt    = r_period;
        w_lock_nxt      = r_lock;
        w_one_match_nxt = r_one_match;

        if (load_pat) begin
            w_per_cnt_nxt   = '0;
            w_period_nxt    = '0;
            w_lock_nxt      = 1'b0;
            w_one_match_nxt = 1'b0;
        end else if (w_hit) begin
            w_period_nxt    = w_per_new;
            w_per_cnt_nxt   = '0;
            w_lock_nxt      = (w_per_new == r_period) && r_one_match;
            w_one_match_nxt = 1'b1;
        end else if (w_accept) begin
            w_per_cnt_nxt   = w_per_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt   <= '0;
            r_period    <= '0;
            r_lock      <= 1'b0;
            r_one_match <= 1'b0;
        end else begin
            r_per_cnt   <= w_per_cnt_nxt;
            r_period    <= w_period_nxt;
            r_lock      <= w_lock_nxt;
            r_one_match <= w_one_match_nxt;
        end
    end

    assign period      = r_period;
    assign period_lock = r_lock;
`else
    assign period      = '0;
    assign period_lock = 1'b0;
`endif

endmodule
